// File: rtl/sound_glu_buffered.sv
// Apple IIgs GLU ($C03C-$C03F) register block. Bus accesses to the data register are posted
// into a small queue and drained one at a time to the sound-RAM port or the DOC register port.
module sound_glu_buffered #(
  parameter bit                    ENABLE     = 1'b1,
  parameter int unsigned           MEM_ADDR_W = 21,
  parameter logic [MEM_ADDR_W-1:0] MEM_BASE   = 21'h04_0000,
  parameter int unsigned           MEM_BYTES  = 4,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter int unsigned           DOC_RD_LAT = 1
) (
  input  logic                   clk_logic,
  input  logic                   system_reset,
  input  logic                   bus_sel_i,
  input  logic [1:0]             bus_addr_i,
  input  logic                   bus_rw_n_i,
  input  logic                   bus_strobe_i,
  input  logic [7:0]             bus_data_i,
  output logic [7:0]             bus_data_o,
  output logic                   bus_rd_en_o,
  output logic                   mem_rd_o,
  output logic                   mem_wr_o,
  output logic [MEM_ADDR_W-1:0]  mem_addr_o,
  output logic [MEM_BYTES-1:0]   mem_byte_en_o,
  output logic [8*MEM_BYTES-1:0] mem_data_o,
  input  logic [8*MEM_BYTES-1:0] mem_q_i,
  input  logic                   mem_ready_i,
  output logic                   doc_wr_o,
  output logic                   doc_rd_o,
  output logic [7:0]             doc_addr_o,
  output logic [7:0]             doc_data_o,
  input  logic [7:0]             doc_q_i,
  output logic [3:0]             volume_o,
  output logic                   overflow_o
);

  localparam int unsigned LaneW     = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int unsigned LaneShift = $clog2(MEM_BYTES);
  localparam int unsigned IdxW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW      = IdxW + 1;

  typedef struct packed {
    logic        ram;
    logic        wr;
    logic [15:0] ptr;
    logic [7:0]  data;
  } entry_t;

  typedef enum logic [2:0] {
    StIdle, StMemWr, StMemRd, StDocWr, StDocRd, StDocWait
  } state_e;

  logic [6:0]            ctrl_q, ctrl_d;
  logic [15:0]           ptr_q, ptr_d;
  logic [7:0]            sound_q, sound_d;
  logic                  overflow_q, overflow_d;
  entry_t                fifo_q [FIFO_DEPTH];
  logic [IdxW-1:0]       rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
  logic [CntW-1:0]       count_q, count_d;
  state_e                state_q, state_d;
  logic [2:0]            lat_q, lat_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [MEM_BYTES-1:0]  byte_en_q, byte_en_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [7:0]            doc_addr_q, doc_addr_d;

  logic          ev, data_acc, empty, full, pop, accept, busy;
  entry_t        head, new_entry;
  logic [LaneW-1:0] lane;
  logic [7:0]    rd_byte;

  assign ev       = ENABLE && bus_strobe_i && bus_sel_i;
  assign data_acc = ev && (bus_addr_i == 2'd1);
  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(FIFO_DEPTH));
  assign pop      = (state_q == StIdle) && !empty;
  // A full queue still accepts when the head leaves on the same edge.
  assign accept   = data_acc && (!full || pop);
  assign head     = fifo_q[rd_idx_q];
  assign busy     = !empty || (state_q != StIdle);
  assign lane     = LaneW'(head.ptr) & LaneW'(MEM_BYTES - 1);

  assign new_entry = '{ram:  ctrl_q[6],
                       wr:   ~bus_rw_n_i,
                       ptr:  ptr_q,
                       data: bus_rw_n_i ? 8'h00 : bus_data_i};

  // Register file and queue bookkeeping.
  always_comb begin
    ctrl_d     = ctrl_q;
    ptr_d      = ptr_q;
    overflow_d = overflow_q;
    rd_idx_d   = rd_idx_q;
    wr_idx_d   = wr_idx_q;
    count_d    = count_q;
    if (ev && !bus_rw_n_i) begin
      unique case (bus_addr_i)
        2'd0: begin
          ctrl_d     = bus_data_i[6:0];
          overflow_d = 1'b0;
        end
        2'd2:    ptr_d[7:0]  = bus_data_i;
        2'd3:    ptr_d[15:8] = bus_data_i;
        default: ;
      endcase
    end
    if (data_acc) begin
      if (ctrl_q[5]) ptr_d = ptr_q + 16'd1;
      if (!accept) overflow_d = 1'b1;
    end
    if (accept) wr_idx_d = wr_idx_q + IdxW'(1);
    if (pop)    rd_idx_d = rd_idx_q + IdxW'(1);
    case ({accept, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Transaction engine.
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    sound_d    = sound_q;
    mem_addr_d = mem_addr_q;
    byte_en_d  = byte_en_q;
    wdata_d    = wdata_q;
    doc_addr_d = doc_addr_q;
    rd_byte    = 8'h00;
    for (int unsigned i = 0; i < MEM_BYTES; i++) begin
      if (byte_en_q[i]) rd_byte = mem_q_i[8*i +: 8];
    end
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          mem_addr_d = MEM_BASE + MEM_ADDR_W'(head.ptr >> LaneShift);
          byte_en_d  = MEM_BYTES'(1) << lane;
          wdata_d    = head.data;
          doc_addr_d = head.ptr[7:0];
          if (head.ram) state_d = head.wr ? StMemWr : StMemRd;
          else          state_d = head.wr ? StDocWr : StDocRd;
        end
      end
      StMemWr: if (mem_ready_i) state_d = StIdle;
      StMemRd: begin
        if (mem_ready_i) begin
          sound_d = rd_byte;
          state_d = StIdle;
        end
      end
      StDocWr: state_d = StIdle;
      StDocRd: begin
        lat_d   = 3'(DOC_RD_LAT - 1);
        state_d = StDocWait;
      end
      StDocWait: begin
        if (lat_q == 3'd0) begin
          sound_d = doc_q_i;
          state_d = StIdle;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_logic or posedge system_reset) begin
    if (system_reset) begin
      ctrl_q     <= 7'h0F;
      ptr_q      <= '0;
      sound_q    <= '0;
      overflow_q <= 1'b0;
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      lat_q      <= '0;
      mem_addr_q <= '0;
      byte_en_q  <= '0;
      wdata_q    <= '0;
      doc_addr_q <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      ptr_q      <= ptr_d;
      sound_q    <= sound_d;
      overflow_q <= overflow_d;
      rd_idx_q   <= rd_idx_d;
      wr_idx_q   <= wr_idx_d;
      count_q    <= count_d;
      state_q    <= state_d;
      lat_q      <= lat_d;
      mem_addr_q <= mem_addr_d;
      byte_en_q  <= byte_en_d;
      wdata_q    <= wdata_d;
      doc_addr_q <= doc_addr_d;
    end
  end

  // Queue storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_logic) begin
    if (accept) fifo_q[wr_idx_q] <= new_entry;
  end

  always_comb begin
    bus_data_o = 8'h00;
    unique case (bus_addr_i)
      2'd0: bus_data_o = {busy, ctrl_q};
      2'd1: bus_data_o = sound_q;
      2'd2: bus_data_o = ptr_q[7:0];
      2'd3: bus_data_o = ptr_q[15:8];
      default: ;
    endcase
  end

  assign bus_rd_en_o   = ENABLE && bus_sel_i && bus_rw_n_i;
  assign mem_wr_o      = ENABLE && (state_q == StMemWr);
  assign mem_rd_o      = ENABLE && (state_q == StMemRd);
  assign doc_wr_o      = ENABLE && (state_q == StDocWr);
  assign doc_rd_o      = ENABLE && (state_q == StDocRd);
  assign mem_addr_o    = mem_addr_q;
  assign mem_byte_en_o = byte_en_q;
  assign mem_data_o    = {MEM_BYTES{wdata_q}};
  assign doc_addr_o    = doc_addr_q;
  assign doc_data_o    = wdata_q;
  assign volume_o      = ctrl_q[3:0];
  assign overflow_o    = overflow_q;

endmodule
